watch_set_ctrl: RTL
===================

Name: watch_set_ctrl

Overview:
User-facing time-setting controller for the watch time counter. It snapshots the running time and lets the user step through the hour, minute and second fields with debounced buttons, incrementing or decrementing each field with wrap-around. On confirm it emits a one-cycle set_watch pulse with the packed {hour,min,sec} word. An edit left idle for too long is abandoned with no write.

Parameters:
TIMEOUT_S, 30, number of en_1hz ticks without a button press before an edit is abandoned (legal range 1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en_1hz  input  1  one-cycle tick, once per second
btn_set  input  1  one-cycle pulse (debounced upstream); starts an edit, advances the field, or commits
btn_up  input  1  one-cycle pulse; increments the active field
btn_down  input  1  one-cycle pulse; decrements the active field
cur_hour  input  5  running hour, 0..23
cur_min  input  6  running minute, 0..59
cur_sec  input  6  running second, 0..59
set_watch  output  1  one-cycle load strobe to the time counter
bin_watch  output  17  {hour[4:0], min[5:0], sec[5:0]} from the edit registers
editing  output  1  high in any edit state
field  output  2  0 = none, 1 = hour, 2 = min, 3 = sec
blink  output  1  display blink phase for the active field

Behaviour:
- Reset (async, rst=0): state IDLE; edit_hour/min/sec=0; set_watch=0; bin_watch=0; editing=0; field=0; blink=0; timeout counter=0.
- States: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT. All outputs are registered or decoded from registered state.
- IDLE:
  - btn_set: load the edit registers from cur_*, then go to EDIT_HOUR.
  - A cur_* value out of range (hour>23, min or sec>59) loads as 0.
  - btn_up and btn_down are ignored.
- EDIT_x, btn_set: EDIT_HOUR->EDIT_MIN->EDIT_SEC->COMMIT.
- EDIT_x, btn_up: field+1. Wraps hour 23->0 and min/sec 59->0.
- EDIT_x, btn_down: field-1. Wraps hour 0->23 and min/sec 0->59.
- Same-cycle priority:
  - btn_set beats up/down; up/down are then ignored that cycle.
  - btn_up and btn_down together: no change, but the timeout counter is still cleared.
- Field independence: changing one field never changes another (no carry or borrow).
- COMMIT: lasts exactly one cycle with set_watch=1, then IDLE unconditionally. Buttons during COMMIT are ignored.
- Commit latency: btn_set sampled in EDIT_SEC at edge N gives set_watch=1 in cycle N+1 and 0 from N+2.
- bin_watch:
  - Always equals {edit_hour, edit_min, edit_sec}.
  - Stable during the set_watch cycle.
  - Holds its last value in IDLE.
- Timeout counter:
  - Cleared on edit entry and on any btn_* pulse.
  - Increments on en_1hz in EDIT states.
  - When it reaches TIMEOUT_S: go to IDLE, no set_watch, edit registers keep their values.
- Simultaneous events in an EDIT state: a button and the tick that would reach TIMEOUT_S in the same cycle -> the button wins (counter cleared, button action taken, no abort).
- Timeout counter width: 8 bits.
- editing=1 in EDIT_HOUR, EDIT_MIN and EDIT_SEC only; 0 in IDLE and COMMIT.
- field = 1/2/3 in EDIT_HOUR/EDIT_MIN/EDIT_SEC, else 0.
- blink:
  - Cleared to 0 on entering EDIT_HOUR and on every field advance.
  - Toggles on en_1hz while editing.
  - Forced to 0 outside the edit states.
- Reset mid-edit: immediate return to reset values; no set_watch is ever emitted by the reset.
- Time keeps running upstream during an edit; the controller never re-samples cur_* after edit entry.

Test Plan:
- Reset, then btn_set with cur=10:20:30 -> EDIT_HOUR, field=1, edit=10:20:30. Three btn_set pulses -> set_watch high for exactly 1 cycle, bin_watch = {5'd10, 6'd20, 6'd30}.
- Wrap: with hour=23, btn_up -> 0. With min=0, btn_down -> 59. With sec=59, btn_up -> 0. The other fields are unchanged and set_watch is never raised.
- Priority: btn_set and btn_up in the same cycle in EDIT_HOUR (hour=5) -> EDIT_MIN, hour stays 5. btn_up and btn_down together in EDIT_MIN -> min unchanged.
- Timeout (TIMEOUT_S=3): enter an edit, apply 3 en_1hz ticks with no buttons -> IDLE, editing=0, no set_watch. Repeat with btn_up coinciding with the 3rd tick -> stays in edit, counter cleared.
- Reset mid-edit: assert rst in EDIT_MIN -> all outputs zero asynchronously. After release, state is IDLE and no set_watch pulse occurs.
- Out-of-range snapshot: cur=25:61:59 on btn_set -> edit registers 0:0:59. Commit -> bin_watch = {5'd0, 6'd0, 6'd59}.

Source files
------------

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: snapshots the running time, lets the user edit hour/min/sec
// with wrap-around, and emits a one-cycle set_watch strobe with the edited word on confirm.
module watch_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_1hz,
  input  logic        btn_set,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [4:0]  cur_hour,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  output logic        set_watch,
  output logic [16:0] bin_watch,
  output logic        editing,
  output logic [1:0]  field,
  output logic        blink
);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    EDIT_SEC,
    COMMIT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_S - 1);

  state_t      state, state_nxt;
  logic [4:0]  edit_hour, hour_nxt;
  logic [5:0]  edit_min, min_nxt;
  logic [5:0]  edit_sec, sec_nxt;
  logic [7:0]  tmo_cnt, tmo_nxt;
  logic        blink_nxt;
  logic        in_edit, nxt_in_edit, any_btn, inc, dec, expire;

  assign in_edit     = (state == EDIT_HOUR) || (state == EDIT_MIN) || (state == EDIT_SEC);
  assign nxt_in_edit = (state_nxt == EDIT_HOUR) || (state_nxt == EDIT_MIN) ||
                       (state_nxt == EDIT_SEC);
  assign any_btn     = btn_set | btn_up | btn_down;
  assign inc         = btn_up & ~btn_down & ~btn_set;
  assign dec         = btn_down & ~btn_up & ~btn_set;
  // The tick that would reach the limit aborts only when no button shares its cycle.
  assign expire      = in_edit & en_1hz & ~any_btn & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      edit_hour <= '0;
      edit_min  <= '0;
      edit_sec  <= '0;
      tmo_cnt   <= '0;
      blink     <= 1'b0;
    end else begin
      state     <= state_nxt;
      edit_hour <= hour_nxt;
      edit_min  <= min_nxt;
      edit_sec  <= sec_nxt;
      tmo_cnt   <= tmo_nxt;
      blink     <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hour_nxt  = edit_hour;
    min_nxt   = edit_min;
    sec_nxt   = edit_sec;
    unique case (state)
      IDLE: begin
        if (btn_set) begin
          state_nxt = EDIT_HOUR;
          hour_nxt  = (cur_hour > 5'd23) ? '0 : cur_hour;
          min_nxt   = (cur_min  > 6'd59) ? '0 : cur_min;
          sec_nxt   = (cur_sec  > 6'd59) ? '0 : cur_sec;
        end
      end
      EDIT_HOUR: begin
        if (btn_set)     state_nxt = EDIT_MIN;
        else if (expire) state_nxt = IDLE;
        if (inc)         hour_nxt = (edit_hour == 5'd23) ? '0 : edit_hour + 5'd1;
        else if (dec)    hour_nxt = (edit_hour == 5'd0) ? 5'd23 : edit_hour - 5'd1;
      end
      EDIT_MIN: begin
        if (btn_set)     state_nxt = EDIT_SEC;
        else if (expire) state_nxt = IDLE;
        if (inc)         min_nxt = (edit_min == 6'd59) ? '0 : edit_min + 6'd1;
        else if (dec)    min_nxt = (edit_min == 6'd0) ? 6'd59 : edit_min - 6'd1;
      end
      EDIT_SEC: begin
        if (btn_set)     state_nxt = COMMIT;
        else if (expire) state_nxt = IDLE;
        if (inc)         sec_nxt = (edit_sec == 6'd59) ? '0 : edit_sec + 6'd1;
        else if (dec)    sec_nxt = (edit_sec == 6'd0) ? 6'd59 : edit_sec - 6'd1;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    tmo_nxt = tmo_cnt;
    if (!in_edit || any_btn || expire) tmo_nxt = '0;
    else if (en_1hz)                   tmo_nxt = tmo_cnt + 8'd1;

    blink_nxt = blink;
    if (!nxt_in_edit || btn_set)  blink_nxt = 1'b0;
    else if (en_1hz && in_edit)   blink_nxt = ~blink;
  end

  always_comb begin
    set_watch = (state == COMMIT);
    editing   = in_edit;
    bin_watch = {edit_hour, edit_min, edit_sec};
    unique case (state)
      EDIT_HOUR: field = 2'd1;
      EDIT_MIN:  field = 2'd2;
      EDIT_SEC:  field = 2'd3;
      default:   field = 2'd0;
    endcase
  end

endmodule
